// File: rtl/fc_layer_gen_if.sv
// ---------------------------------------------------------------------------
// fc_layer_gen_if
// Bundles the streaming and weight-write signals of the fully-connected
// layer generator.
//
// Signals:
//   input_valid / input_ready / input_data    activation stream x[0..N-1]
//   output_valid / output_ready / output_data result stream y[0..M-1]
//   w_wr_en / w_addr / w_data                 weight write port, addr = row*N+col
//
// Modports:
//   master : the side that feeds activations and weights and consumes results
//   slave  : the layer itself
// ---------------------------------------------------------------------------
interface fc_layer_gen_if #(
    parameter int M = 4,
    parameter int N = 8,
    parameter int T = 16
);
    localparam int AW = (M * N > 1) ? $clog2(M * N) : 1;

    logic                 input_valid;
    logic                 input_ready;
    logic signed [T-1:0]  input_data;

    logic                 output_valid;
    logic                 output_ready;
    logic signed [T-1:0]  output_data;

    logic                 w_wr_en;
    logic [AW-1:0]        w_addr;
    logic signed [T-1:0]  w_data;

    modport master (
        output input_valid,
        output input_data,
        input  input_ready,
        input  output_valid,
        input  output_data,
        output output_ready,
        output w_wr_en,
        output w_addr,
        output w_data
    );

    modport slave (
        input  input_valid,
        input  input_data,
        output input_ready,
        output output_valid,
        output output_data,
        input  output_ready,
        input  w_wr_en,
        input  w_addr,
        input  w_data
    );
endinterface

// File: rtl/fc_layer_gen.sv
// ---------------------------------------------------------------------------
// fc_layer_gen
// Fully-connected layer y = act(W * x) for an M x N signed weight matrix.
// Activations stream in (LOAD), the rows are evaluated P at a time by P
// parallel MAC lanes (COMPUTE), and each group of P results streams out in
// lane order (EMIT). After the last group the block returns to LOAD.
//
// Each result is arithmetic-shifted right by FRAC, saturated to the signed
// T-bit range and, when RELU=1, clamped at zero.
//
// Parameters:
//   M    output neurons (rows), must be a multiple of P
//   N    input activations (columns)
//   T    signed data width
//   P    parallel MAC lanes
//   FRAC fractional bits dropped from each result
//   RELU 1 enables ReLU on the outputs
//
// Ports:
//   clk   rising-edge clock
//   reset asynchronous, active-low reset
//   bus   fc_layer_gen_if.slave (activation stream, result stream, weights)
// ---------------------------------------------------------------------------
module fc_layer_gen #(
    parameter int M    = 4,
    parameter int N    = 8,
    parameter int T    = 16,
    parameter int P    = 1,
    parameter int FRAC = 0,
    parameter int RELU = 1
) (
    input  logic          clk,
    input  logic          reset,
    fc_layer_gen_if.slave bus
);

    localparam int ACCW = 2 * T + $clog2(N);
    localparam int PW   = 2 * T;
    localparam int G    = M / P;
    localparam int CW   = (N > 1) ? $clog2(N) : 1;
    localparam int SW   = $clog2(N + 2);
    localparam int GW   = (G > 1) ? $clog2(G) : 1;
    localparam int LW   = (P > 1) ? $clog2(P) : 1;
    localparam int AW   = (M * N > 1) ? $clog2(M * N) : 1;

    localparam logic signed [ACCW-1:0] SAT_MAX = {{(ACCW - T + 1){1'b0}}, {(T - 1){1'b1}}};
    localparam logic signed [ACCW-1:0] SAT_MIN = {{(ACCW - T + 1){1'b1}}, {(T - 1){1'b0}}};

    typedef enum logic [1:0] {
        LOAD,
        COMPUTE,
        EMIT
    } state_t;

    state_t               state;
    logic [CW-1:0]        cnt;
    logic [SW-1:0]        step;
    logic [GW-1:0]        g;
    logic [LW-1:0]        lane;
    logic [LW-1:0]        next_lane;
    logic [CW-1:0]        col;

    logic signed [T-1:0]    w_mem [M*N];
    logic signed [T-1:0]    x_mem [N];
    logic signed [PW-1:0]   prod  [P];
    logic signed [ACCW-1:0] acc   [P];
    logic [AW-1:0]          rd_idx [P];
    logic signed [T-1:0]    res   [P];
    logic signed [T-1:0]    next_res;

    logic in_fire;
    logic out_fire;

    assign in_fire  = bus.input_valid & bus.input_ready;
    assign out_fire = bus.output_valid & bus.output_ready;
    assign col      = CW'(step);

    // Shift, saturate, then optionally ReLU one accumulator value.
    function automatic logic signed [T-1:0] saturate(input logic signed [ACCW-1:0] a);
        logic signed [ACCW-1:0] s;
        logic signed [T-1:0]    r;
        s = a >>> FRAC;
        if (s > SAT_MAX) begin
            r = SAT_MAX[T-1:0];
        end else if (s < SAT_MIN) begin
            r = SAT_MIN[T-1:0];
        end else begin
            r = s[T-1:0];
        end
        if (RELU != 0 && r[T-1]) begin
            r = '0;
        end
        return r;
    endfunction

    // Weight address of row g*P+l, column col for every lane.
    always_comb begin
        for (int l = 0; l < P; l++) begin
            rd_idx[l] = AW'((int'(g) * P + l) * N + int'(col));
        end
    end

    // Final results per lane, and the one that goes out after the current lane.
    always_comb begin
        next_lane = lane + LW'(1);
        next_res  = '0;
        for (int l = 0; l < P; l++) begin
            res[l] = saturate(acc[l]);
        end
        for (int l = 0; l < P; l++) begin
            if (LW'(l) == next_lane) begin
                next_res = res[l];
            end
        end
    end

    // Weights are deliberately not reset so they survive across frames and resets.
    always_ff @(posedge clk) begin
        if (bus.w_wr_en && state != COMPUTE) begin
            w_mem[bus.w_addr] <= bus.w_data;
        end
    end

    // Activation buffer; a restarted frame simply overwrites stale entries.
    always_ff @(posedge clk) begin
        if (state == LOAD && in_fire) begin
            x_mem[cnt] <= bus.input_data;
        end
    end

    // COMPUTE is a two-stage pipeline: step 0..N-1 registers products,
    // step 1..N adds them, and step N+1 hands lane 0's result to the output
    // register, so output_valid rises N+2 edges after COMPUTE is entered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= LOAD;
            cnt              <= '0;
            step             <= '0;
            g                <= '0;
            lane             <= '0;
            bus.input_ready  <= 1'b1;
            bus.output_valid <= 1'b0;
            bus.output_data  <= '0;
            for (int l = 0; l < P; l++) begin
                acc[l]  <= '0;
                prod[l] <= '0;
            end
        end else begin
            case (state)
                LOAD: begin
                    if (in_fire) begin
                        if (cnt == CW'(N - 1)) begin
                            cnt             <= '0;
                            g               <= '0;
                            step            <= '0;
                            bus.input_ready <= 1'b0;
                            state           <= COMPUTE;
                            for (int l = 0; l < P; l++) begin
                                acc[l] <= '0;
                            end
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end

                COMPUTE: begin
                    for (int l = 0; l < P; l++) begin
                        if (step < SW'(N)) begin
                            prod[l] <= PW'(w_mem[rd_idx[l]]) * PW'(x_mem[col]);
                        end
                        if (step != '0 && step <= SW'(N)) begin
                            acc[l] <= acc[l] + ACCW'(prod[l]);
                        end
                    end
                    if (step == SW'(N + 1)) begin
                        lane             <= '0;
                        bus.output_valid <= 1'b1;
                        bus.output_data  <= res[0];
                        state            <= EMIT;
                    end else begin
                        step <= step + SW'(1);
                    end
                end

                EMIT: begin
                    if (out_fire) begin
                        if (lane == LW'(P - 1)) begin
                            lane             <= '0;
                            bus.output_valid <= 1'b0;
                            if (g == GW'(G - 1)) begin
                                g               <= '0;
                                cnt             <= '0;
                                bus.input_ready <= 1'b1;
                                state           <= LOAD;
                            end else begin
                                g     <= g + GW'(1);
                                step  <= '0;
                                state <= COMPUTE;
                                for (int l = 0; l < P; l++) begin
                                    acc[l] <= '0;
                                end
                            end
                        end else begin
                            lane            <= next_lane;
                            bus.output_data <= next_res;
                        end
                    end
                end

                default: begin
                    state <= LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fc_layer_gen.sv
// ---------------------------------------------------------------------------
// tb_fc_layer_gen
// Drives five fc_layer_gen instances (M=4, N=8, T=16) from one shared
// stimulus: P=1/RELU=1, P=1/RELU=0, P=2, P=4, and P=1/FRAC=4.
// Directed frames come from a table of hand-computed results; reset,
// stall and random-weight frames are hand-written sequences.
// ---------------------------------------------------------------------------
module tb_fc_layer_gen;

    localparam int M  = 4;
    localparam int N  = 8;
    localparam int T  = 16;
    localparam int ND = 5;

    localparam int P_TAB    [ND] = '{1, 1, 2, 4, 1};
    localparam int FRAC_TAB [ND] = '{0, 0, 0, 0, 4};
    localparam int RELU_TAB [ND] = '{1, 0, 1, 1, 1};

    localparam int WP_KEEP  = 0;
    localparam int WP_IDENT = 1;
    localparam int WP_MAX   = 2;
    localparam int WP_FRAC  = 3;
    localparam int WP_RAND  = 4;

    typedef struct {
        int wpat;
        int x      [N];
        int y_relu [M];
        int y_lin  [M];
        int y_frac [M];
        bit stall;
        bit wrc;
    } vec_t;

    logic                clk;
    logic                reset;
    logic                in_valid;
    logic                out_ready;
    logic                w_wr_en;
    logic signed [T-1:0] in_data;
    logic signed [T-1:0] w_data;
    logic [4:0]          w_addr;

    logic [ND-1:0]       rdy_vec;
    logic [ND-1:0]       vld_vec;
    logic signed [T-1:0] dat_vec [ND];

    logic signed [T-1:0] cap [ND][64];
    int                  wp  [ND];
    int                  rp  [ND];

    int   wt [M*N];
    int   xv [N];
    int   errors;
    int   checks;
    vec_t vecs [7];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    for (genvar k = 0; k < ND; k++) begin : g_dut
        fc_layer_gen_if #(.M(M), .N(N), .T(T)) bus ();

        assign bus.input_valid  = in_valid;
        assign bus.input_data   = in_data;
        assign bus.output_ready = out_ready;
        assign bus.w_wr_en      = w_wr_en;
        assign bus.w_addr       = w_addr;
        assign bus.w_data       = w_data;
        assign rdy_vec[k]       = bus.input_ready;
        assign vld_vec[k]       = bus.output_valid;
        assign dat_vec[k]       = bus.output_data;

        fc_layer_gen #(
            .M(M), .N(N), .T(T),
            .P(P_TAB[k]), .FRAC(FRAC_TAB[k]), .RELU(RELU_TAB[k])
        ) dut (
            .clk  (clk),
            .reset(reset),
            .bus  (bus)
        );
    end

    // Inputs change at posedge+1, so the negedge sees the settled handshake.
    always @(negedge clk) begin
        for (int k = 0; k < ND; k++) begin
            if (vld_vec[k] && out_ready) begin
                cap[k][wp[k] % 64] <= dat_vec[k];
                wp[k]              <= wp[k] + 1;
            end
        end
    end

    task automatic checkOutput(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("[TB] FAIL %s got=%0d expected=%0d", name, got, exp);
        end
    endtask

    function automatic int model(input int i, input int frac, input int relu);
        longint acc;
        acc = 0;
        for (int j = 0; j < N; j++) begin
            acc += longint'(wt[i * N + j]) * longint'(xv[j]);
        end
        acc = acc >>> frac;
        if (acc > 32767) acc = 32767;
        else if (acc < -32768) acc = -32768;
        if (relu != 0 && acc < 0) acc = 0;
        return int'(acc);
    endfunction

    task automatic load_weights(input int pat);
        int v;
        logic signed [T-1:0] r;
        for (int a = 0; a < M * N; a++) begin
            case (pat)
                WP_IDENT: v = (a / N == a % N) ? 1 : 0;
                WP_MAX:   v = 32767;
                WP_FRAC:  v = (a == 0) ? 32 : 0;
                default: begin
                    r = 16'($urandom);
                    v = int'(r);
                end
            endcase
            wt[a] = v;
            @(posedge clk); #1;
            w_wr_en = 1'b1;
            w_addr  = 5'(a);
            w_data  = 16'(v);
        end
        @(posedge clk); #1;
        w_wr_en = 1'b0;
    endtask

    // Returns at posedge+1 of the edge that takes the last activation.
    task automatic applyStimulus();
        int waitc;
        waitc = 0;
        @(posedge clk); #1;
        while (rdy_vec != '1 && waitc < 100) begin
            @(posedge clk); #1;
            waitc++;
        end
        checkOutput("input_ready_before_frame", int'(rdy_vec == '1), 1);
        in_valid = 1'b1;
        in_data  = 16'(xv[0]);
        for (int j = 1; j < N; j++) begin
            @(posedge clk); #1;
            in_data = 16'(xv[j]);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Waits until every instance has emitted M results, optionally stalling
    // with ready = 1,0,0,... and poking weight 0 while COMPUTE is running.
    task automatic collect(input bit stall, input bit wrc);
        int cyc;
        int first;
        bit hold;
        bit done;
        logic signed [T-1:0] held;
        cyc   = 0;
        first = -1;
        hold  = 1'b0;
        done  = 1'b0;
        held  = '0;
        while (!done && cyc < 400) begin
            @(posedge clk); #1;
            cyc++;
            if (hold) begin
                checkOutput("stall_valid_held", int'(vld_vec[0]), 1);
                checkOutput("stall_data_held", int'(dat_vec[0]), int'(held));
            end
            if (first < 0 && vld_vec[0]) first = cyc;
            w_wr_en   = wrc && (cyc == 2 || cyc == 3);
            w_addr    = '0;
            w_data    = 16'sd100;
            out_ready = stall ? (cyc % 3 == 1) : 1'b1;
            hold      = vld_vec[0] && !out_ready;
            held      = dat_vec[0];
            done      = 1'b1;
            for (int k = 0; k < ND; k++) begin
                if (wp[k] < rp[k] + M) done = 1'b0;
            end
        end
        w_wr_en   = 1'b0;
        out_ready = 1'b1;
        checkOutput("frame_complete", int'(done), 1);
        checkOutput("first_valid_latency", first, N + 2);
    endtask

    task automatic compare_table(input vec_t v, input int idx);
        int exp;
        int got;
        for (int k = 0; k < ND; k++) begin
            for (int i = 0; i < M; i++) begin
                exp = (k == 1) ? v.y_lin[i] : (k == 4) ? v.y_frac[i] : v.y_relu[i];
                got = int'(cap[k][rp[k] % 64]);
                rp[k]++;
                checkOutput($sformatf("vec%0d_dut%0d_y%0d", idx, k, i), got, exp);
            end
        end
    endtask

    task automatic compare_model(input string tag);
        int got;
        for (int k = 0; k < ND; k++) begin
            for (int i = 0; i < M; i++) begin
                got = int'(cap[k][rp[k] % 64]);
                rp[k]++;
                checkOutput($sformatf("%s_dut%0d_y%0d", tag, k, i), got,
                            model(i, FRAC_TAB[k], RELU_TAB[k]));
            end
        end
    endtask

    initial begin
        logic signed [T-1:0] rnd;
        errors    = 0;
        checks    = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        w_wr_en   = 1'b0;
        w_addr    = '0;
        w_data    = '0;
        for (int k = 0; k < ND; k++) rp[k] = 0;

        vecs[0].wpat = WP_IDENT; vecs[0].x = '{1, 2, 3, 4, 5, 6, 7, 8};
        vecs[0].y_relu = '{1, 2, 3, 4}; vecs[0].y_lin = '{1, 2, 3, 4}; vecs[0].y_frac = '{0, 0, 0, 0};
        vecs[0].stall = 0; vecs[0].wrc = 0;

        vecs[1].wpat = WP_KEEP; vecs[1].x = '{-5, 7, -100, 300, 9, 9, 9, 9};
        vecs[1].y_relu = '{0, 7, 0, 300}; vecs[1].y_lin = '{-5, 7, -100, 300}; vecs[1].y_frac = '{0, 0, 0, 18};
        vecs[1].stall = 0; vecs[1].wrc = 0;

        vecs[2].wpat = WP_KEEP; vecs[2].x = '{1, 2, 3, 4, 5, 6, 7, 8};
        vecs[2].y_relu = '{1, 2, 3, 4}; vecs[2].y_lin = '{1, 2, 3, 4}; vecs[2].y_frac = '{0, 0, 0, 0};
        vecs[2].stall = 1; vecs[2].wrc = 0;

        vecs[3].wpat = WP_MAX; vecs[3].x = '{32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767};
        vecs[3].y_relu = '{32767, 32767, 32767, 32767}; vecs[3].y_lin = '{32767, 32767, 32767, 32767};
        vecs[3].y_frac = '{32767, 32767, 32767, 32767}; vecs[3].stall = 0; vecs[3].wrc = 0;

        vecs[4].wpat = WP_KEEP; vecs[4].x = '{-32767, -32767, -32767, -32767, -32767, -32767, -32767, -32767};
        vecs[4].y_relu = '{0, 0, 0, 0}; vecs[4].y_lin = '{-32768, -32768, -32768, -32768};
        vecs[4].y_frac = '{0, 0, 0, 0}; vecs[4].stall = 0; vecs[4].wrc = 0;

        vecs[5].wpat = WP_FRAC; vecs[5].x = '{3, 1, 2, 3, 4, 5, 6, 7};
        vecs[5].y_relu = '{96, 0, 0, 0}; vecs[5].y_lin = '{96, 0, 0, 0}; vecs[5].y_frac = '{6, 0, 0, 0};
        vecs[5].stall = 0; vecs[5].wrc = 1;

        vecs[6].wpat = WP_KEEP; vecs[6].x = '{3, 1, 2, 3, 4, 5, 6, 7};
        vecs[6].y_relu = '{96, 0, 0, 0}; vecs[6].y_lin = '{96, 0, 0, 0}; vecs[6].y_frac = '{6, 0, 0, 0};
        vecs[6].stall = 0; vecs[6].wrc = 0;

        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < ND; k++) begin
            checkOutput($sformatf("reset_input_ready_dut%0d", k), int'(rdy_vec[k]), 1);
            checkOutput($sformatf("reset_output_valid_dut%0d", k), int'(vld_vec[k]), 0);
            checkOutput($sformatf("reset_output_data_dut%0d", k), int'(dat_vec[k]), 0);
        end
        @(negedge clk);
        reset = 1'b1;

        for (int v = 0; v < 7; v++) begin
            if (vecs[v].wpat != WP_KEEP) load_weights(vecs[v].wpat);
            xv = vecs[v].x;
            applyStimulus();
            collect(vecs[v].stall, vecs[v].wrc);
            compare_table(vecs[v], v);
        end

        // Abort a frame in COMPUTE; the next frame must use only new inputs.
        xv = '{50, 40, 30, 20, 10, 0, -10, -20};
        applyStimulus();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        for (int k = 0; k < ND; k++) begin
            checkOutput($sformatf("midreset_output_valid_dut%0d", k), int'(vld_vec[k]), 0);
            checkOutput($sformatf("midreset_input_ready_dut%0d", k), int'(rdy_vec[k]), 1);
        end
        @(negedge clk);
        reset = 1'b1;
        xv = '{5, 1, 1, 1, 1, 1, 1, 1};
        applyStimulus();
        collect(1'b0, 1'b0);
        compare_model("after_reset");

        for (int r = 0; r < 3; r++) begin
            load_weights(WP_RAND);
            for (int j = 0; j < N; j++) begin
                rnd   = 16'($urandom);
                xv[j] = int'(rnd);
            end
            applyStimulus();
            collect(1'b0, 1'b0);
            compare_model($sformatf("rand%0d", r));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
